// File: rtl/seg_size_calc_pipe.sv
// seg_size_calc_pipe: two-stage valid/ready pipeline that picks the next TX
// segment length for one flow. The length is limited by unsent data, the
// usable peer window and the effective MSS. The block also flags zero-window
// probes and inconsistent send-buffer pointers.
// Stage 1 registers the pointer differences, the usable window and the clamped
// MSS. Stage 2 registers the final response and drives the outputs directly.
module seg_size_calc_pipe #(
  parameter int PTR_W        = 11,
  parameter int WIN_SIZE_W   = 16,
  parameter int MAX_SEG_SIZE = 1024,
  parameter int FLOWID_W     = 8,
  parameter int PROBE_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic [FLOWID_W-1:0]   req_flowid,
  input  logic [PTR_W:0]        req_trail_ptr,
  input  logic [PTR_W:0]        req_next_send_ptr,
  input  logic [PTR_W:0]        req_lead_ptr,
  input  logic [WIN_SIZE_W-1:0] req_curr_win,
  input  logic [PTR_W:0]        req_mss,
  output logic                  resp_val,
  input  logic                  resp_rdy,
  output logic [FLOWID_W-1:0]   resp_flowid,
  output logic [PTR_W:0]        resp_seg_size,
  output logic                  resp_probe,
  output logic                  resp_err
);

  // Pointer width including the wrap bit.
  localparam int PW = PTR_W + 1;
  // Common width for window comparisons. It is wide enough for both the
  // window and any pointer difference.
  localparam int W = (WIN_SIZE_W > PW) ? WIN_SIZE_W : PW;
  localparam logic [PW-1:0] MSS_MAX = PW'(MAX_SEG_SIZE);

  // Smaller of two W-bit unsigned values.
  function automatic logic [W-1:0] min_w(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    if (a < b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

  // Stage 1 combinational results.
  logic [PW-1:0] unsent_s;
  logic [PW-1:0] in_flight_s;
  logic [PW-1:0] total_s;
  logic          err_s;
  logic [W-1:0]  win_avail_s;
  logic [PW-1:0] mss_eff_s;

  // Stage 1 registers.
  logic                s1_val_r;
  logic [FLOWID_W-1:0] s1_flowid_r;
  logic [PW-1:0]       s1_unsent_r;
  logic [W-1:0]        s1_win_avail_r;
  logic [PW-1:0]       s1_mss_eff_r;
  logic                s1_err_r;

  // Stage 2 next-state values.
  logic [PW-1:0] seg_next_s;
  logic          probe_next_s;
  logic          err_next_s;

  // Handshake control.
  logic s2_adv_s;

  // Stage 2 can take new data when it is empty or is draining this cycle.
  assign s2_adv_s = ~resp_val | resp_rdy;
  // Stage 1 accepts a request when it is empty or can move forward into stage 2.
  assign req_rdy  = ~s1_val_r | s2_adv_s;

  // Stage 1 arithmetic: modular pointer distances, usable window and clamped MSS.
  always_comb begin
    unsent_s    = req_lead_ptr - req_next_send_ptr;
    in_flight_s = req_next_send_ptr - req_trail_ptr;
    total_s     = req_lead_ptr - req_trail_ptr;
    // Bytes in flight cannot exceed the total buffered data.
    err_s       = (in_flight_s > total_s);
    if (W'(req_curr_win) > W'(in_flight_s)) begin
      win_avail_s = W'(req_curr_win) - W'(in_flight_s);
    end else begin
      win_avail_s = {W{1'b0}};
    end
    if ((req_mss == {PW{1'b0}}) || (req_mss > MSS_MAX)) begin
      mss_eff_s = MSS_MAX;
    end else begin
      mss_eff_s = req_mss;
    end
  end

  // Stage 1 register: load a new request when ready; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val_r       <= 1'b0;
      s1_flowid_r    <= {FLOWID_W{1'b0}};
      s1_unsent_r    <= {PW{1'b0}};
      s1_win_avail_r <= {W{1'b0}};
      s1_mss_eff_r   <= {PW{1'b0}};
      s1_err_r       <= 1'b0;
    end else if (req_rdy) begin
      s1_val_r <= req_val;
      if (req_val) begin
        s1_flowid_r    <= req_flowid;
        s1_unsent_r    <= unsent_s;
        s1_win_avail_r <= win_avail_s;
        s1_mss_eff_r   <= mss_eff_s;
        s1_err_r       <= err_s;
      end else begin
        s1_flowid_r <= s1_flowid_r;
      end
    end else begin
      s1_val_r <= s1_val_r;
    end
  end

  // Stage 2 decision: report an error, send a zero-window probe, or send a limited segment.
  always_comb begin
    seg_next_s   = {PW{1'b0}};
    probe_next_s = 1'b0;
    err_next_s   = 1'b0;
    if (s1_err_r) begin
      err_next_s = 1'b1;
    end else if ((s1_win_avail_r == {W{1'b0}}) && (s1_unsent_r != {PW{1'b0}}) &&
                 (PROBE_EN != 0)) begin
      seg_next_s   = {{(PW-1){1'b0}}, 1'b1};
      probe_next_s = 1'b1;
    end else begin
      // The unsent byte count bounds the minimum, so it fits in PW bits.
      seg_next_s = PW'(min_w(min_w(W'(s1_unsent_r), s1_win_avail_r), W'(s1_mss_eff_r)));
    end
  end

  // Stage 2 register: drives the response outputs and holds them while the response is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_val      <= 1'b0;
      resp_flowid   <= {FLOWID_W{1'b0}};
      resp_seg_size <= {PW{1'b0}};
      resp_probe    <= 1'b0;
      resp_err      <= 1'b0;
    end else if (s2_adv_s) begin
      resp_val <= s1_val_r;
      if (s1_val_r) begin
        resp_flowid   <= s1_flowid_r;
        resp_seg_size <= seg_next_s;
        resp_probe    <= probe_next_s;
        resp_err      <= err_next_s;
      end else begin
        resp_flowid <= resp_flowid;
      end
    end else begin
      resp_val <= resp_val;
    end
  end

endmodule

// File: tb/tb_seg_size_calc_pipe.sv
// Testbench for seg_size_calc_pipe. A reference model works out each response
// from the segment-size rules using plain integer arithmetic. A scoreboard
// queue checks every drained response in order. Directed vectors cover latency,
// wrap, probe, error, backpressure and reset.
module tb_seg_size_calc_pipe;

  localparam int PW = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_val;
  logic        req_rdy;
  logic [7:0]  req_flowid;
  logic [11:0] req_trail_ptr, req_next_send_ptr, req_lead_ptr;
  logic [15:0] req_curr_win;
  logic [11:0] req_mss;
  logic        resp_val;
  logic        resp_rdy;
  logic [7:0]  resp_flowid;
  logic [11:0] resp_seg_size;
  logic        resp_probe, resp_err;
  // Second instance with probes disabled, fed the same stimulus.
  logic        np_req_rdy, np_resp_val, np_resp_probe, np_resp_err;
  logic [7:0]  np_resp_flowid;
  logic [11:0] np_resp_seg_size;

  always #5 clk = ~clk;

  seg_size_calc_pipe dut (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy),
    .req_flowid(req_flowid), .req_trail_ptr(req_trail_ptr),
    .req_next_send_ptr(req_next_send_ptr), .req_lead_ptr(req_lead_ptr),
    .req_curr_win(req_curr_win), .req_mss(req_mss), .resp_val(resp_val),
    .resp_rdy(resp_rdy), .resp_flowid(resp_flowid), .resp_seg_size(resp_seg_size),
    .resp_probe(resp_probe), .resp_err(resp_err));

  seg_size_calc_pipe #(.PROBE_EN(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(np_req_rdy),
    .req_flowid(req_flowid), .req_trail_ptr(req_trail_ptr),
    .req_next_send_ptr(req_next_send_ptr), .req_lead_ptr(req_lead_ptr),
    .req_curr_win(req_curr_win), .req_mss(req_mss), .resp_val(np_resp_val),
    .resp_rdy(resp_rdy), .resp_flowid(np_resp_flowid), .resp_seg_size(np_resp_seg_size),
    .resp_probe(np_resp_probe), .resp_err(np_resp_err));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit bp_phase = 1'b0;
  int drain_cyc [8];

  typedef struct {
    int fid;
    int seg;
    bit probe;
    bit err;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference rules: 12-bit modular pointers, window compared as a plain integer.
  function automatic void model(input int t, input int n, input int l, input int w,
                                input int m, input bit pe,
                                output int seg, output bit probe, output bit err);
    int unsent, inflight, total, wa, me;
    unsent   = (l - n) & 4095;
    inflight = (n - t) & 4095;
    total    = (l - t) & 4095;
    wa       = (w > inflight) ? w - inflight : 0;
    me       = (m == 0 || m > 1024) ? 1024 : m;
    err      = (inflight > total);
    probe    = 1'b0;
    seg      = 0;
    if (err) seg = 0;
    else if (wa == 0 && unsent != 0 && pe) begin
      seg = 1;
      probe = 1'b1;
    end else begin
      seg = unsent;
      if (wa < seg) seg = wa;
      if (me < seg) seg = me;
    end
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: hold stability, scoreboard compare on drain, push on accept.
  logic       hold_prev = 1'b0;
  logic [7:0] p_fid;
  logic [11:0] p_seg;
  logic       p_probe, p_err;
  always @(negedge clk) begin
    exp_t e;
    int s;
    bit pr, er;
    if (!rst_n) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_val", resp_val, 1);
        check("hold_fid", resp_flowid, p_fid);
        check("hold_seg", resp_seg_size, p_seg);
        check("hold_probe", resp_probe, p_probe);
        check("hold_err", resp_err, p_err);
      end
      if (resp_val && resp_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_fid", resp_flowid, e.fid);
          check("sb_seg", resp_seg_size, e.seg);
          check("sb_probe", resp_probe, e.probe);
          check("sb_err", resp_err, e.err);
          if (bp_phase && e.fid >= 1 && e.fid <= 5) drain_cyc[e.fid] = cyc;
        end
      end
      if (req_val && req_rdy) begin
        model(req_trail_ptr, req_next_send_ptr, req_lead_ptr, req_curr_win, req_mss,
              1'b1, s, pr, er);
        e.fid = req_flowid; e.seg = s; e.probe = pr; e.err = er;
        sb.push_back(e);
      end
      hold_prev = resp_val && !resp_rdy;
      p_fid = resp_flowid; p_seg = resp_seg_size; p_probe = resp_probe; p_err = resp_err;
    end
  end

  // Must be called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input int fid, input int t, input int n, input int l,
                      input int w, input int m);
    bit ok;
    req_flowid = 8'(fid); req_trail_ptr = 12'(t); req_next_send_ptr = 12'(n);
    req_lead_ptr = 12'(l); req_curr_win = 16'(w); req_mss = 12'(m);
    req_val = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = req_rdy;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
    req_val = 1'b0;
  endtask

  // Waits for a response, checks the literal expectations, then lets it drain.
  task automatic expect_resp(input string name, input int fid, input int seg,
                             input bit probe, input bit err, input int np_seg,
                             input bit np_probe);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = resp_val;
    end
    check({name, "_val"}, resp_val, 1);
    check({name, "_fid"}, resp_flowid, fid);
    check({name, "_seg"}, resp_seg_size, seg);
    check({name, "_probe"}, resp_probe, probe);
    check({name, "_err"}, resp_err, err);
    check({name, "_np_seg"}, np_resp_seg_size, np_seg);
    check({name, "_np_probe"}, np_resp_probe, np_probe);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c0;
    bit pr, er;
    for (int i = 0; i < 8; i++) drain_cyc[i] = -1;
    rst_n = 1'b0; req_val = 1'b0; resp_rdy = 1'b1; req_flowid = 8'd0;
    req_trail_ptr = 12'd0; req_next_send_ptr = 12'd0; req_lead_ptr = 12'd0;
    req_curr_win = 16'd0; req_mss = 12'd0;

    // Pin the model with hand-computed values.
    model(100, 300, 2000, 1000, 0, 1'b1, s, pr, er);   check("model_win", s, 800);
    model(4000, 4090, 50, 65535, 1500, 1'b1, s, pr, er); check("model_wrap", s, 56);
    model(4000, 4090, 3000, 65535, 1500, 1'b1, s, pr, er); check("model_clamp", s, 1024);
    model(0, 200, 900, 100, 0, 1'b1, s, pr, er);       check("model_probe", {s[15:0], 15'd0, pr}, 32'h00010001);
    model(0, 200, 100, 100, 0, 1'b1, s, pr, er);       check("model_err", {s[30:0], er}, 1);

    #12;
    check("rst_resp_val", resp_val, 0);
    check("rst_req_rdy", req_rdy, 1);
    check("rst_seg", resp_seg_size, 0);
    check("rst_fid", resp_flowid, 0);
    check("rst_flags", {resp_probe, resp_err}, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Window limit and latency.
    send(8'h11, 100, 300, 2000, 1000, 0);
    @(negedge clk); check("lat_early", resp_val, 0);
    @(negedge clk);
    check("lat_val", resp_val, 1);
    check("win_seg", resp_seg_size, 800);
    check("win_fid", resp_flowid, 8'h11);
    check("win_flags", {resp_probe, resp_err}, 0);
    @(posedge clk); #1;

    send(8'h12, 4000, 4090, 50, 65535, 1500);
    expect_resp("wrap", 8'h12, 56, 1'b0, 1'b0, 56, 1'b0);
    send(8'h13, 4000, 4090, 3000, 65535, 1500);
    expect_resp("clamp", 8'h13, 1024, 1'b0, 1'b0, 1024, 1'b0);
    send(8'h14, 0, 200, 900, 100, 0);
    expect_resp("closed", 8'h14, 1, 1'b1, 1'b0, 0, 1'b0);
    send(8'h15, 0, 200, 200, 100, 0);
    expect_resp("nothing", 8'h15, 0, 1'b0, 1'b0, 0, 1'b0);
    send(8'h16, 0, 200, 100, 5000, 0);
    expect_resp("badptr", 8'h16, 0, 1'b0, 1'b1, 0, 1'b0);
    send(8'h17, 10, 10, 1010, 5000, 300);
    expect_resp("mss", 8'h17, 300, 1'b0, 1'b0, 300, 1'b0);

    // Backpressure: two accepts fill the pipe, then drain in order.
    bp_phase = 1'b1;
    resp_rdy = 1'b0;
    send(1, 0, 0, 100, 1000, 0);
    send(2, 0, 0, 200, 1000, 0);
    @(negedge clk);
    check("bp_rdy_low", req_rdy, 0);
    check("bp_head_fid", resp_flowid, 1);
    repeat (4) @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    send(3, 0, 0, 300, 1000, 0);
    send(4, 0, 0, 400, 1000, 0);
    send(5, 0, 0, 500, 1000, 0);
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 5; k++) check("bp_drain_cycle", drain_cyc[k], drain_cyc[1] + k - 1);
    check("bp_drain_seen", (drain_cyc[1] > 0), 1);
    bp_phase = 1'b0;
    @(posedge clk); #1;

    // Reset mid-flight.
    resp_rdy = 1'b0;
    send(8'h21, 0, 0, 100, 1000, 0);
    send(8'h22, 0, 0, 100, 1000, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_val", resp_val, 0);
    check("mid_rst_rdy", req_rdy, 1);
    check("mid_rst_fid", resp_flowid, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stale_resp", resp_val, 0);
    end
    @(posedge clk); #1;
    c0 = cyc;
    send(8'h23, 100, 300, 2000, 1000, 0);
    check("accept_next_edge", cyc - c0, 1);
    expect_resp("post_rst", 8'h23, 800, 1'b0, 1'b0, 800, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
